// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard/flush sequencer: turns ID/EX hazard events into a registered
// which_flush code plus PC and IF/ID stall enables.
module hazard_flush_ctrl #(
    parameter logic [3:0]  OP_LOAD      = 4'b1011,
    parameter logic [3:0]  OP_JUMP      = 4'b0111,
    parameter logic [3:0]  OP_HALT      = 4'b0000,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] id_opcode,
    input  logic [3:0] id_rs,
    input  logic [3:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic [3:0] ex_opcode,
    input  logic [3:0] ex_rd,
    input  logic       ex_branch_valid,
    input  logic       ex_branch_taken,
    input  logic       exc_req,
    output logic [1:0] which_flush,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       halted,
    output logic       busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] EXC   = 3'd1;
    localparam logic [2:0] BR1   = 3'd2;
    localparam logic [2:0] BR2   = 3'd3;
    localparam logic [2:0] STALL = 3'd4;
    localparam logic [2:0] JMP   = 3'd5;
    localparam logic [2:0] HALT  = 3'd6;

    localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] idle_next;
    logic       luh, br_taken;

    logic [1:0] flush_d;
    logic       pc_stall_d, ifid_stall_d, halted_d, busy_d;

    assign br_taken = ex_branch_valid & ex_branch_taken;
    assign luh = (ex_opcode == OP_LOAD) && (ex_rd != 4'd0) &&
                 ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));

    // Fixed priority HALT > EXC > BR1 > STALL > JMP, shared by every re-evaluating state.
    always_comb begin
        idle_next = IDLE;
        if (id_opcode == OP_HALT)      idle_next = HALT;
        else if (exc_req)              idle_next = EXC;
        else if (br_taken)             idle_next = BR1;
        else if (luh)                  idle_next = STALL;
        else if (id_opcode == OP_JUMP) idle_next = JMP;
    end

    always_comb begin
        state_d = idle_next;
        cnt_d   = cnt_q;
        case (state_q)
            BR1:  state_d = BR2;
            BR2:  state_d = IDLE;
            HALT: state_d = HALT;
            STALL: begin
                if (exc_req) begin
                    state_d = EXC;
                end else if (br_taken) begin
                    state_d = BR1;
                end else if (cnt_q != 3'd0) begin
                    state_d = STALL;
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            default: state_d = idle_next;
        endcase
        if (state_d == STALL && state_q != STALL) cnt_d = STALL_INIT;
        if (state_d != STALL) cnt_d = 3'd0;
    end

    // Outputs are decoded from the next state so they land registered with it.
    always_comb begin
        flush_d      = 2'b11;
        pc_stall_d   = 1'b0;
        ifid_stall_d = 1'b0;
        halted_d     = 1'b0;
        busy_d       = (state_d != IDLE);
        case (state_d)
            EXC:   flush_d = 2'b10;
            BR1:   flush_d = 2'b00;
            BR2:   flush_d = 2'b01;
            JMP:   flush_d = 2'b00;
            STALL: begin
                flush_d      = 2'b01;
                pc_stall_d   = 1'b1;
                ifid_stall_d = 1'b1;
            end
            HALT: begin
                flush_d      = 2'b00;
                pc_stall_d   = 1'b1;
                ifid_stall_d = 1'b1;
                halted_d     = 1'b1;
            end
            default: flush_d = 2'b11;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            which_flush <= 2'b11;
            pc_stall    <= 1'b0;
            ifid_stall  <= 1'b0;
            halted      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            which_flush <= flush_d;
            pc_stall    <= pc_stall_d;
            ifid_stall  <= ifid_stall_d;
            halted      <= halted_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl: two instances (STALL_CYCLES = 1 and 3)
// share stimulus; outputs packed as {which_flush, pc_stall, ifid_stall, halted, busy}.
module tb_hazard_flush_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] id_opcode, id_rs, id_rt, ex_opcode, ex_rd;
    logic       id_rs_used, id_rt_used, ex_branch_valid, ex_branch_taken, exc_req;

    logic [1:0] wf1, wf3;
    logic       pcs1, ifs1, h1, b1, pcs3, ifs3, h3, b3;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] E_IDLE = 6'b11_0000;
    localparam logic [5:0] E_STL  = 6'b01_1101;
    localparam logic [5:0] E_BR1  = 6'b00_0001;
    localparam logic [5:0] E_BR2  = 6'b01_0001;
    localparam logic [5:0] E_EXC  = 6'b10_0001;
    localparam logic [5:0] E_JMP  = 6'b00_0001;
    localparam logic [5:0] E_HLT  = 6'b00_1111;

    always #5 clk = ~clk;

    hazard_flush_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_opcode(ex_opcode),
        .ex_rd(ex_rd), .ex_branch_valid(ex_branch_valid), .ex_branch_taken(ex_branch_taken),
        .exc_req(exc_req), .which_flush(wf1), .pc_stall(pcs1), .ifid_stall(ifs1),
        .halted(h1), .busy(b1)
    );

    hazard_flush_ctrl #(.STALL_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_opcode(ex_opcode),
        .ex_rd(ex_rd), .ex_branch_valid(ex_branch_valid), .ex_branch_taken(ex_branch_taken),
        .exc_req(exc_req), .which_flush(wf3), .pc_stall(pcs3), .ifid_stall(ifs3),
        .halted(h3), .busy(b3)
    );

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        id_opcode = 4'b0001; id_rs = 4'd0; id_rt = 4'd0;
        id_rs_used = 1'b0; id_rt_used = 1'b0;
        ex_opcode = 4'b0001; ex_rd = 4'd0;
        ex_branch_valid = 1'b0; ex_branch_taken = 1'b0; exc_req = 1'b0;
    endtask

    task automatic set_luh(input logic [3:0] rd);
        ex_opcode = 4'b1011; ex_rd = rd; id_rs = 4'd3; id_rs_used = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        for (int i = 0; i < 3; i++) begin
            id_opcode = 4'($urandom); id_rs = 4'($urandom); id_rt = 4'($urandom);
            ex_opcode = 4'($urandom); ex_rd = 4'($urandom);
            {id_rs_used, id_rt_used, ex_branch_valid, ex_branch_taken, exc_req} =
                5'($urandom);
            step();
            check("reset", {wf1, pcs1, ifs1, h1, b1}, E_IDLE);
            check("reset3", {wf3, pcs3, ifs3, h3, b3}, E_IDLE);
        end
        quiet();
        rst_n = 1'b1;
        step();
        check("idle", {wf1, pcs1, ifs1, h1, b1}, E_IDLE);
        step();
        check("idle2", {wf1, pcs1, ifs1, h1, b1}, E_IDLE);

        // Load-use: 1 stall on dut, 3 on dut3
        set_luh(4'd3);
        step();
        check("lu_stall", {wf1, pcs1, ifs1, h1, b1}, E_STL);
        check("lu3_s1", {wf3, pcs3, ifs3, h3, b3}, E_STL);
        quiet();
        step();
        check("lu_done", {wf1, pcs1, ifs1, h1, b1}, E_IDLE);
        check("lu3_s2", {wf3, pcs3, ifs3, h3, b3}, E_STL);
        step();
        check("lu3_s3", {wf3, pcs3, ifs3, h3, b3}, E_STL);
        step();
        check("lu3_done", {wf3, pcs3, ifs3, h3, b3}, E_IDLE);

        // rt path also triggers
        ex_opcode = 4'b1011; ex_rd = 4'd9; id_rt = 4'd9; id_rt_used = 1'b1;
        step();
        check("lu_rt", {wf1, pcs1, ifs1, h1, b1}, E_STL);
        quiet();
        step();
        step();
        step();
        check("lu_rt_done3", {wf3, pcs3, ifs3, h3, b3}, E_IDLE);

        // ex_rd = 0 never stalls; unused match never stalls
        set_luh(4'd0);
        id_rs = 4'd0;
        step();
        check("lu_rd0", {wf1, pcs1, ifs1, h1, b1}, E_IDLE);
        set_luh(4'd3);
        id_rs_used = 1'b0;
        step();
        check("lu_unused", {wf1, pcs1, ifs1, h1, b1}, E_IDLE);
        quiet();

        // Taken branch, load-use injected in BR1/BR2 ignored
        ex_branch_valid = 1'b1; ex_branch_taken = 1'b1;
        step();
        check("br1", {wf1, pcs1, ifs1, h1, b1}, E_BR1);
        quiet();
        set_luh(4'd3);
        step();
        check("br2", {wf1, pcs1, ifs1, h1, b1}, E_BR2);
        step();
        check("br_done", {wf1, pcs1, ifs1, h1, b1}, E_IDLE);
        quiet();
        ex_branch_valid = 1'b1; ex_branch_taken = 1'b0;
        step();
        check("br_not_taken", {wf1, pcs1, ifs1, h1, b1}, E_IDLE);
        quiet();

        // Jump
        id_opcode = 4'b0111;
        step();
        check("jmp", {wf1, pcs1, ifs1, h1, b1}, E_JMP);
        quiet();
        step();
        check("jmp_done", {wf1, pcs1, ifs1, h1, b1}, E_IDLE);

        // Priority: exception beats branch and jump; branch not re-presented
        exc_req = 1'b1; ex_branch_valid = 1'b1; ex_branch_taken = 1'b1; id_opcode = 4'b0111;
        step();
        check("prio_exc", {wf1, pcs1, ifs1, h1, b1}, E_EXC);
        quiet();
        step();
        check("prio_after", {wf1, pcs1, ifs1, h1, b1}, E_IDLE);

        // Preemption of a 3-cycle stall by a taken branch in the second stall cycle
        set_luh(4'd3);
        step();
        check("pre_s1", {wf3, pcs3, ifs3, h3, b3}, E_STL);
        quiet();
        step();
        check("pre_s2", {wf3, pcs3, ifs3, h3, b3}, E_STL);
        ex_branch_valid = 1'b1; ex_branch_taken = 1'b1;
        step();
        check("pre_br1", {wf3, pcs3, ifs3, h3, b3}, E_BR1);
        quiet();
        step();
        check("pre_br2", {wf3, pcs3, ifs3, h3, b3}, E_BR2);
        step();
        check("pre_done", {wf3, pcs3, ifs3, h3, b3}, E_IDLE);

        // Halt is sticky until reset
        id_opcode = 4'b0000;
        step();
        check("halt", {wf1, pcs1, ifs1, h1, b1}, E_HLT);
        quiet();
        exc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_hold", {wf1, pcs1, ifs1, h1, b1}, E_HLT);
        end
        quiet();
        rst_n = 1'b0;
        step();
        check("halt_reset", {wf1, pcs1, ifs1, h1, b1}, E_IDLE);
        rst_n = 1'b1;
        step();
        check("post_reset", {wf1, pcs1, ifs1, h1, b1}, E_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Pipeline hazard and flush sequencer. It watches the ID and EX stages and produces the 2-bit which_flush code consumed by the control unit, plus the PC and IF/ID stall enables.
- It handles load-use stalls, taken-branch squashes, jump squashes, exception flushes and halt.
- It sits beside the control unit, between the hazard inputs from ID/EX and the pipeline-register enable/flush logic.

Parameters:
- OP_LOAD, 4'b1011, opcode treated as a memory load.
- OP_JUMP, 4'b0111, unconditional jump resolved in ID.
- OP_HALT, 4'b0000, halt opcode.
- STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_opcode  in  4  opcode of instruction in ID
- id_rs  in  4  ID source register A
- id_rt  in  4  ID source register B
- id_rs_used  in  1  id_rs is a real read
- id_rt_used  in  1  id_rt is a real read
- ex_opcode  in  4  opcode of instruction in EX
- ex_rd  in  4  EX destination register
- ex_branch_valid  in  1  EX holds a resolved conditional branch
- ex_branch_taken  in  1  branch outcome, qualified by ex_branch_valid
- exc_req  in  1  exception request from EX
- which_flush  out  2  flush code: 00 = IF/ID, 01 = ID/EX, 10 = EX/MEM, 11 = none
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- halted  out  1  core halted (sticky)
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: which_flush = 11, pc_stall = 0, ifid_stall = 0, halted = 0, busy = 0, state IDLE, counter 0.
- Reset is sampled only on the clock edge. Asserting reset mid-sequence returns every output to its reset value on the next edge and aborts any sequence.
- All outputs are registered. The response appears on the edge after the inputs are sampled, so latency is 1 cycle.
- Load-use hazard (luh): ex_opcode == OP_LOAD, ex_rd != 0, and either (id_rs_used and id_rs == ex_rd) or (id_rt_used and id_rt == ex_rd).
- IDLE, priority highest first; each branch's outputs are shown in parentheses:
  - id_opcode == OP_HALT -> HALT.
  - exc_req -> EXC (which_flush = 10).
  - ex_branch_valid and ex_branch_taken -> BR1 (which_flush = 00).
  - luh -> STALL (which_flush = 01, pc_stall = 1, ifid_stall = 1, counter = STALL_CYCLES - 1).
  - id_opcode == OP_JUMP -> JMP (which_flush = 00).
  - otherwise stay in IDLE with which_flush = 11 and stalls at 0.
- EXC and JMP each last 1 cycle, then re-evaluate exactly as in IDLE.
- BR1 -> BR2 unconditionally. BR2 drives which_flush = 01 and stalls at 0, then re-evaluates as IDLE.
- All inputs except rst_n are ignored during BR1 and BR2, because both squashed stages are dead.
- STALL behaviour:
  - Outputs held at which_flush = 01, pc_stall = 1, ifid_stall = 1.
  - When counter == 0, re-evaluate as IDLE. A still-present luh can never recur, since EX now holds a bubble.
  - Otherwise decrement the counter.
  - Preemption: exc_req or a taken branch during STALL aborts the counter. The FSM goes to EXC or BR1 next cycle and pc_stall/ifid_stall drop.
- HALT is terminal until reset: which_flush = 00, pc_stall = 1, ifid_stall = 1, halted = 1, busy = 1.
- Simultaneous events resolve by the fixed priority HALT > EXC > BR1 > STALL > JMP.
- busy = (state != IDLE), registered along with the other outputs.
- The counter is 3 bits wide; the implementation must be correct for STALL_CYCLES = 7.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with random inputs -> which_flush = 11, all other outputs 0. Release reset -> IDLE persists with no hazards.
- Load-use: ex_opcode = 1011, ex_rd = 3, id_rs = 3, id_rs_used = 1, default STALL_CYCLES -> exactly 1 cycle of which_flush = 01 with both stalls high, then 11. Repeat with STALL_CYCLES = 3 -> 3 stall cycles. Repeat with ex_rd = 0 -> no stall.
- Taken branch: ex_branch_valid = 1, ex_branch_taken = 1 -> which_flush sequence 00 then 01, then 11. A load-use hazard injected during BR2 is ignored. A not-taken branch produces no flush.
- Priority: exc_req, a taken branch and a jump opcode in the same cycle -> which_flush = 10 for one cycle. The branch is then re-evaluated only if still presented.
- Preemption: STALL_CYCLES = 3 and a taken branch in the second stall cycle -> stalls drop, then 00, 01, 11.
- Halt: id_opcode = 0000 -> halted = 1, which_flush = 00 and both stalls high indefinitely. Pulse rst_n low for one edge -> all outputs return to reset values.
